geared_bit_bank: RTL and testbench
==================================

GEARED_BIT_BANK -- requirements
Module: geared_bit_bank

Interface
REQ-001 Parameter N_BITS, default 4: number of geared bits sharing one gear train (range 1..32).
REQ-002 Parameter INIT, default 0: reset value of the shared gear state V.
REQ-003 Parameter INV_MASK, default 0 (N_BITS wide): bit k set means bit k is mounted inverted, so its local state is V ^ INV_MASK[k].
REQ-004 Parameter CNT_W, default 16: width of the ball counter.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 i_left  input  N_BITS  one-cycle pulse: ball enters bit k from its left.
REQ-008 i_right  input  N_BITS  one-cycle pulse: ball enters bit k from its right.
REQ-009 o_left  output  N_BITS  one-cycle pulse: ball leaves bit k to the left.
REQ-010 o_right  output  N_BITS  one-cycle pulse: ball leaves bit k to the right.
REQ-011 o_state  output  N_BITS  local state of every bit (V ^ INV_MASK).
REQ-012 o_busy  output  1  high while the FSM is in TURNING.
REQ-013 o_collision  output  1  sticky error flag for a dropped or extra ball.
REQ-014 o_count  output  CNT_W  number of balls routed since reset.

Function
REQ-015 The FSM SHALL have two states, IDLE and TURNING.
REQ-016 In IDLE, any asserted bit of i_left|i_right SHALL be accepted, and the FSM SHALL move to TURNING on the next edge.
REQ-017 On acceptance, the FSM SHALL latch the accepted index k and the decision d = V ^ INV_MASK[k], both taken from the pre-toggle state.
REQ-018 In TURNING, exactly one of o_left[k] (d=0) or o_right[k] (d=1) SHALL be high for one cycle; all other outputs are zero, giving a latency of 1 cycle.
REQ-019 On the edge ending TURNING: V SHALL toggle, o_count SHALL increment, and the FSM SHALL return to IDLE.
REQ-020 o_count SHALL wrap from 2^CNT_W-1 to 0 silently.
REQ-021 Simultaneous arrivals in one IDLE cycle (multiple k, or i_left[k] and i_right[k] together) SHALL be handled as follows:
- the lowest index k is accepted;
- all other balls are dropped;
- o_collision is set.
REQ-022 Any arrival while in TURNING SHALL be dropped and SHALL set o_collision; state and count are unaffected.
REQ-023 o_collision SHALL clear only on reset.
REQ-024 A ball accepted in the same cycle TURNING exits SHALL be impossible, because back-to-back acceptance needs IDLE; the maximum rate is one ball every 2 cycles.
REQ-025 o_state SHALL reflect V combinationally from the register, changing the cycle after TURNING.
REQ-026 All outputs SHALL be driven from registers or from register-only logic; there are no combinational paths from input to output.

Reset
REQ-027 While rst is high, on the clock edge the block SHALL set:
- V to INIT;
- FSM to IDLE;
- o_left and o_right to 0;
- o_busy to 0;
- o_collision to 0;
- o_count to 0.
REQ-028 Reset in TURNING SHALL abort the pending exit: no output pulse, no toggle, no count increment.
REQ-029 Inputs sampled in a cycle where rst is high SHALL be ignored.

Structure
REQ-030 Package tt_pkg SHALL hold the FSM state enum (TT_IDLE, TT_TURNING) and the constant TT_MAX_BITS = 32.
REQ-031 Lowest-index selection SHALL be a sub-module tt_ball_arbiter with the following ports:
- input: N_BITS request vector;
- outputs: one-hot grant, index, and a multi-request flag.
REQ-032 The shared gear state SHALL be a single register V; per-bit state SHALL NOT be stored separately.

Verification
REQ-033 N_BITS=4, INIT=0, INV_MASK=0, with i_left[2] pulsed at t -> o_left[2]=1 at t+1, o_state=4'b1111 from t+2, o_count=1.
REQ-034 The same configuration with INV_MASK=4'b0010, and i_right[1] pulsed from reset -> o_right[1]=1 at t+1; afterwards o_state=4'b1101.
REQ-035 i_left[3] and i_right[0] pulsed in the same cycle -> bit 0 routed, o_collision=1, o_count=1, no output on bit 3.
REQ-036 i_left[0] at t and i_left[1] at t+1 -> second ball dropped, o_collision=1, V toggled once only.
REQ-037 CNT_W=2, with 5 balls spaced 2 cycles apart -> o_count sequence 1,2,3,0,1 and alternating o_left/o_right on the ball's bit.
REQ-038 rst asserted at t+1 after an accepted ball -> no output pulse, V=INIT, o_count=0, o_busy=0 at t+2.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and constants for the geared bit bank.
package tt_pkg;

    localparam int unsigned TT_MAX_BITS = 32;

    typedef enum logic {
        TT_IDLE    = 1'b0,
        TT_TURNING = 1'b1
    } tt_state_e;

    // Index width for an N-entry vector; never narrower than one bit.
    function automatic int unsigned tt_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/geared_bit_bank_if.sv
// Ball entry/exit pulse bundle between the bank and its neighbours.
interface geared_bit_bank_if #(
    parameter int unsigned N_BITS = 4
);
    logic [N_BITS-1:0] i_left;
    logic [N_BITS-1:0] i_right;
    logic [N_BITS-1:0] o_left;
    logic [N_BITS-1:0] o_right;

    modport master (
        output i_left,
        output i_right,
        input  o_left,
        input  o_right
    );

    modport slave (
        input  i_left,
        input  i_right,
        output o_left,
        output o_right
    );
endinterface

// File: rtl/tt_ball_arbiter.sv
// Lowest-index-wins selection among simultaneous ball arrivals.
module tt_ball_arbiter
    import tt_pkg::*;
#(
    parameter int unsigned N_BITS = 4,
    localparam int unsigned IDX_W = tt_idx_w(N_BITS)
) (
    input  logic [N_BITS-1:0] req,
    output logic [N_BITS-1:0] grant,
    output logic [IDX_W-1:0]  index,
    output logic              multi
);

    localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

    // Isolate the lowest set request and flag any additional requests.
    always_comb begin
        grant = req & (~req + ONE);
        multi = |(req & (req - ONE));
        index = '0;
        for (int unsigned i = N_BITS; i > 0; i--) begin
            if (req[i-1]) begin
                index = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/geared_bit_bank.sv
// Bank of geared bits sharing one gear state V; routes one ball per two cycles.
module geared_bit_bank
    import tt_pkg::*;
#(
    parameter int unsigned       N_BITS   = 4,
    parameter logic              INIT     = 1'b0,
    parameter logic [N_BITS-1:0] INV_MASK = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    geared_bit_bank_if.slave     bus,
    output logic [N_BITS-1:0]    o_state,
    output logic                 o_busy,
    output logic                 o_collision,
    output logic [CNT_W-1:0]     o_count
);

    localparam int unsigned       IDX_W = tt_idx_w(N_BITS);
    localparam logic [N_BITS-1:0] ONE   = N_BITS'(1);

    tt_state_e         state_q;
    logic              v_q;
    logic              d_q;
    logic [IDX_W-1:0]  k_q;
    logic [CNT_W-1:0]  count_q;
    logic              coll_q;

    logic [N_BITS-1:0] req;
    logic [N_BITS-1:0] grant;
    logic [IDX_W-1:0]  idx;
    logic              multi;
    logic [N_BITS-1:0] pulse;

    assign req = bus.i_left | bus.i_right;

    tt_ball_arbiter #(
        .N_BITS (N_BITS)
    ) u_arb (
        .req   (req),
        .grant (grant),
        .index (idx),
        .multi (multi)
    );

    // Accept in IDLE, emit in TURNING, then toggle the gear and count the ball.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TT_IDLE;
            v_q     <= INIT;
            d_q     <= 1'b0;
            k_q     <= '0;
            count_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            case (state_q)
                TT_IDLE: begin
                    if (|req) begin
                        state_q <= TT_TURNING;
                        k_q     <= idx;
                        d_q     <= v_q ^ (|(grant & INV_MASK));
                        if (multi || (|(bus.i_left & bus.i_right))) begin
                            coll_q <= 1'b1;
                        end
                    end
                end
                TT_TURNING: begin
                    state_q <= TT_IDLE;
                    v_q     <= ~v_q;
                    count_q <= count_q + CNT_W'(1);
                    if (|req) begin
                        coll_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Exit pulses are decoded from the latched index and decision only,
    // so reset during TURNING suppresses the pulse by leaving TURNING.
    assign pulse       = ONE << k_q;
    assign o_busy      = (state_q == TT_TURNING);
    assign bus.o_left  = (o_busy && !d_q) ? pulse : '0;
    assign bus.o_right = (o_busy &&  d_q) ? pulse : '0;
    assign o_state     = {N_BITS{v_q}} ^ INV_MASK;
    assign o_collision = coll_q;
    assign o_count     = count_q;

endmodule

// File: tb/tb_geared_bit_bank.sv
// Directed checks of the geared bit bank across three configurations.
module tb_geared_bit_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_tests  = 0;
    int unsigned n_failed = 0;

    geared_bit_bank_if #(.N_BITS(4)) ifa ();
    geared_bit_bank_if #(.N_BITS(4)) ifb ();
    geared_bit_bank_if #(.N_BITS(4)) ifc ();

    logic [3:0]  a_state, b_state, c_state;
    logic        a_busy,  b_busy,  c_busy;
    logic        a_coll,  b_coll,  c_coll;
    logic [15:0] a_count, b_count;
    logic [1:0]  c_count;

    geared_bit_bank #(.N_BITS(4), .INIT(1'b0), .INV_MASK(4'b0000), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave),
        .o_state(a_state), .o_busy(a_busy), .o_collision(a_coll), .o_count(a_count)
    );

    geared_bit_bank #(.N_BITS(4), .INIT(1'b0), .INV_MASK(4'b0010), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave),
        .o_state(b_state), .o_busy(b_busy), .o_collision(b_coll), .o_count(b_count)
    );

    geared_bit_bank #(.N_BITS(4), .INIT(1'b0), .INV_MASK(4'b0000), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.slave),
        .o_state(c_state), .o_busy(c_busy), .o_collision(c_coll), .o_count(c_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        ifa.i_left = '0; ifa.i_right = '0;
        ifb.i_left = '0; ifb.i_right = '0;
        ifc.i_left = '0; ifc.i_right = '0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        check("rst_state",  a_state, 4'b0000);
        check("rst_count",  a_count, 0);
        check("rst_busy",   a_busy, 0);
        check("rst_coll",   a_coll, 0);
        check("rst_left",   ifa.o_left, 0);
        check("rst_right",  ifa.o_right, 0);
        check("rst_b_state", b_state, 4'b0010);

        // Single ball on bit 2, V=0 -> exits left
        ifa.i_left = 4'b0100;
        step();
        ifa.i_left = '0;
        check("b1_left",  ifa.o_left, 4'b0100);
        check("b1_right", ifa.o_right, 4'b0000);
        check("b1_busy",  a_busy, 1);
        check("b1_pre_state", a_state, 4'b0000);
        step();
        check("b1_state", a_state, 4'b1111);
        check("b1_count", a_count, 1);
        check("b1_left_done", ifa.o_left, 0);
        check("b1_idle", a_busy, 0);
        check("b1_no_coll", a_coll, 0);

        // Simultaneous arrivals on bits 3 and 0; V=1 so bit 0 exits right
        ifa.i_left  = 4'b1000;
        ifa.i_right = 4'b0001;
        step();
        ifa.i_left  = '0;
        ifa.i_right = '0;
        check("sim_right", ifa.o_right, 4'b0001);
        check("sim_left",  ifa.o_left, 4'b0000);
        step();
        check("sim_count", a_count, 2);
        check("sim_coll",  a_coll, 1);
        check("sim_state", a_state, 4'b0000);

        // Arrival during TURNING is dropped
        do_reset();
        check("rst2_coll", a_coll, 0);
        ifa.i_left = 4'b0001;
        step();
        ifa.i_left = 4'b0010;
        check("drop_first", ifa.o_left, 4'b0001);
        step();
        ifa.i_left = '0;
        check("drop_count", a_count, 1);
        check("drop_coll",  a_coll, 1);
        check("drop_state", a_state, 4'b1111);
        check("drop_busy",  a_busy, 0);
        step();
        check("drop_no_exit", ifa.o_left | ifa.o_right, 0);
        check("drop_count2",  a_count, 1);

        // Reset while TURNING aborts the exit; inputs under reset ignored
        do_reset();
        ifa.i_left = 4'b0010;
        step();
        check("abort_acc", ifa.o_left, 4'b0010);
        rst = 1'b1;
        ifa.i_left = 4'b1000;
        step();
        check("abort_left",  ifa.o_left, 0);
        check("abort_right", ifa.o_right, 0);
        check("abort_state", a_state, 4'b0000);
        check("abort_count", a_count, 0);
        check("abort_busy",  a_busy, 0);
        rst = 1'b0;
        ifa.i_left = '0;
        step();
        check("abort_busy2",  a_busy, 0);
        check("abort_count2", a_count, 0);
        check("abort_coll",   a_coll, 0);

        // Inverted bit 1, V=0 -> decision 1, exits right
        ifb.i_right = 4'b0010;
        step();
        ifb.i_right = '0;
        check("inv_right", ifb.o_right, 4'b0010);
        check("inv_left",  ifb.o_left, 4'b0000);
        step();
        check("inv_state", b_state, 4'b1101);
        check("inv_count", b_count, 1);

        // Two-bit counter wrap with alternating exits on bit 2
        do_reset();
        for (int unsigned b = 0; b < 5; b++) begin
            ifc.i_left = 4'b0100;
            step();
            ifc.i_left = '0;
            check("wrap_left",  ifc.o_left,  (b % 2 == 0) ? 4'b0100 : 4'b0000);
            check("wrap_right", ifc.o_right, (b % 2 == 0) ? 4'b0000 : 4'b0100);
            step();
            check("wrap_count", c_count, (b + 1) % 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
